// File: rtl/writeback_regfile.sv
// Writeback stage: result select, 32-entry integer register file with
// same-cycle write bypass, and a committed-writeback counter.
module writeback_regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            RegWriteW,
    input  logic [1:0]      ResultSrcW,
    input  logic [XLEN-1:0] ALUResultW,
    input  logic [XLEN-1:0] ReadDataW,
    input  logic [XLEN-1:0] PCPlus4W,
    input  logic [XLEN-1:0] ImmExtW,
    input  logic [AW-1:0]   RdW,
    input  logic [AW-1:0]   Rs1D,
    input  logic [AW-1:0]   Rs2D,
    output logic [XLEN-1:0] RD1D,
    output logic [XLEN-1:0] RD2D,
    output logic [XLEN-1:0] ResultW,
    output logic [63:0]     wb_count
);

    logic [XLEN-1:0] regs [NREG];
    logic            commit;
    logic            byp1;
    logic            byp2;

    always_comb begin
        ResultW = ALUResultW;
        unique case (ResultSrcW)
            2'b00: ResultW = ALUResultW;
            2'b01: ResultW = ReadDataW;
            2'b10: ResultW = PCPlus4W;
            2'b11: ResultW = ImmExtW;
        endcase
    end

    assign commit = RegWriteW && (RdW != '0);

    // Bypass is held off during reset so every read returns zero.
    assign byp1 = rst_n && commit && (Rs1D == RdW);
    assign byp2 = rst_n && commit && (Rs2D == RdW);

    always_comb begin
        RD1D = '0;
        RD2D = '0;
        if (Rs1D != '0) RD1D = byp1 ? ResultW : regs[Rs1D];
        if (Rs2D != '0) RD2D = byp2 ? ResultW : regs[Rs2D];
    end

    // regs[0] is only ever cleared, so it reads as zero even if indexed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (commit) begin
            regs[RdW] <= ResultW;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_count <= '0;
        end else if (commit) begin
            wb_count <= wb_count + 64'd1;
        end
    end

endmodule

// File: tb/tb_writeback_regfile.sv
// Bench for writeback_regfile: directed tables, corner sequences and
// randomized traffic against an array-based register file model.
module tb_writeback_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [31:0] PCPlus4W;
    logic [31:0] ImmExtW;
    logic [4:0]  RdW;
    logic [4:0]  Rs1D;
    logic [4:0]  Rs2D;
    logic [31:0] RD1D;
    logic [31:0] RD2D;
    logic [31:0] ResultW;
    logic [63:0] wb_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_regs [32];
    logic [63:0] m_cnt;

    writeback_regfile dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .RegWriteW (RegWriteW),
        .ResultSrcW(ResultSrcW),
        .ALUResultW(ALUResultW),
        .ReadDataW (ReadDataW),
        .PCPlus4W  (PCPlus4W),
        .ImmExtW   (ImmExtW),
        .RdW       (RdW),
        .Rs1D      (Rs1D),
        .Rs2D      (Rs2D),
        .RD1D      (RD1D),
        .RD2D      (RD2D),
        .ResultW   (ResultW),
        .wb_count  (wb_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  src;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [4];

    task automatic chk32(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk64(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] m_result();
        case (ResultSrcW)
            2'd0: return ALUResultW;
            2'd1: return ReadDataW;
            2'd2: return PCPlus4W;
            default: return ImmExtW;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0 || !rst_n) return 32'd0;
        if (RegWriteW && RdW != 0 && RdW == a) return m_result();
        return m_regs[a];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_cnt = 64'd0;
    endtask

    // Called just after a negedge: apply, check combinational outputs,
    // clock once, update model, check counter at the next negedge.
    task automatic cyc(input string nm, input logic we,
                       input logic [1:0] src, input logic [31:0] a,
                       input logic [31:0] l, input logic [31:0] p,
                       input logic [31:0] im, input logic [4:0] rd,
                       input logic [4:0] r1, input logic [4:0] r2);
        RegWriteW = we; ResultSrcW = src;
        ALUResultW = a; ReadDataW = l; PCPlus4W = p; ImmExtW = im;
        RdW = rd; Rs1D = r1; Rs2D = r2;
        #1;
        chk32({nm, ".res"}, ResultW, m_result());
        chk32({nm, ".rd1"}, RD1D, m_read(r1));
        chk32({nm, ".rd2"}, RD2D, m_read(r2));
        @(posedge clk);
        if (rst_n && we && rd != 0) begin
            m_regs[rd] = m_result();
            m_cnt = m_cnt + 64'd1;
        end
        @(negedge clk);
        chk64({nm, ".cnt"}, wb_count, m_cnt);
    endtask

    task automatic rd_only(input string nm, input logic [4:0] r1,
                           input logic [4:0] r2);
        cyc(nm, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, r1, r2);
    endtask

    initial begin
        rst_n = 1'b0;
        RegWriteW = 1'b0; ResultSrcW = 2'd0;
        ALUResultW = '0; ReadDataW = '0; PCPlus4W = '0; ImmExtW = '0;
        RdW = '0; Rs1D = '0; Rs2D = '0;
        m_reset();

        tbl[0] = '{2'd0, 5'd5, 32'h11111111};
        tbl[1] = '{2'd1, 5'd6, 32'h22222222};
        tbl[2] = '{2'd2, 5'd7, 32'h00000104};
        tbl[3] = '{2'd3, 5'd8, 32'h12345000};

        repeat (2) @(negedge clk);
        Rs1D = 5'd3; Rs2D = 5'd17;
        #1;
        chk32("inrst.rd1", RD1D, 32'd0);
        chk32("inrst.rd2", RD2D, 32'd0);
        chk64("inrst.cnt", wb_count, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 32; i++) begin
            rd_only("rstread", 5'(i), 5'(31 - i));
            chk32("rstread.zero", RD1D, 32'd0);
        end

        for (int i = 0; i < 4; i++) begin
            cyc("src", 1'b1, tbl[i].src, 32'h11111111, 32'h22222222,
                32'h00000104, 32'h12345000, tbl[i].rd, 5'd0, 5'd0);
            chk32("src.mux", ResultW, tbl[i].exp);
        end
        for (int i = 0; i < 4; i++) begin
            rd_only("readback", tbl[i].rd, tbl[i].rd);
            chk32("readback.val", RD2D, tbl[i].exp);
        end
        chk64("readback.cnt4", wb_count, 64'd4);

        cyc("x0wr", 1'b1, 2'd0, 32'hDEADBEEF, 32'd0, 32'd0, 32'd0,
            5'd0, 5'd0, 5'd0);
        rd_only("x0rd", 5'd0, 5'd0);
        chk64("x0.cnt", wb_count, 64'd4);

        cyc("x9init", 1'b1, 2'd0, 32'hAAAAAAAA, 32'd0, 32'd0, 32'd0,
            5'd9, 5'd0, 5'd0);
        RegWriteW = 1'b1; ResultSrcW = 2'd1; ReadDataW = 32'h55555555;
        ALUResultW = 32'd0; RdW = 5'd9; Rs1D = 5'd9; Rs2D = 5'd9;
        #1;
        chk32("byp.rd1", RD1D, 32'h55555555);
        chk32("byp.rd2", RD2D, 32'h55555555);
        RegWriteW = 1'b0;
        #1;
        chk32("nobyp.rd1", RD1D, 32'hAAAAAAAA);
        chk32("nobyp.rd2", RD2D, 32'hAAAAAAAA);
        @(negedge clk);

        for (int n = 0; n < 400; n++) begin
            cyc("rand", 1'($urandom_range(0, 2) != 0),
                2'($urandom), $urandom, $urandom, $urandom, $urandom,
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 8)),
                5'($urandom_range(0, 8)));
        end

        RegWriteW = 1'b1; ResultSrcW = 2'd0; ALUResultW = 32'hCAFEF00D;
        RdW = 5'd10; Rs1D = 5'd10; Rs2D = 5'd10;
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        chk32("arst.rd1", RD1D, 32'd0);
        chk64("arst.cnt", wb_count, 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rd_only("postrst", 5'd10, 5'd9);
        chk32("postrst.x10", RD1D, 32'd0);
        cyc("firstwr", 1'b1, 2'd3, 32'd0, 32'd0, 32'd0, 32'h77000000,
            5'd10, 5'd10, 5'd0);
        chk64("firstwr.cnt1", wb_count, 64'd1);
        rd_only("firstrd", 5'd10, 5'd10);
        chk32("firstrd.x10", RD1D, 32'h77000000);

        force dut.wb_count = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.wb_count;
        m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
        cyc("wrap", 1'b1, 2'd0, 32'h1, 32'd0, 32'd0, 32'd0,
            5'd12, 5'd0, 5'd0);
        chk64("wrap.zero", wb_count, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
